// File: rtl/sub_div_ctrl.sv
// sub_div_ctrl: restoring 4-bit unsigned divider sequencing an external a-b-c subtractor
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 division request, honoured only when idle
//   dividend, divisor     operands captured on an accepted start
//   sub_a, sub_b, sub_c   operand drive to the shared subtractor (zero when not calculating)
//   sub_diff, sub_cout    subtractor result and borrow-out (1 = a < b + c)
//   busy                  high from accept through the done cycle
//   done                  one-cycle pulse, results valid
//   quotient, remainder   results, held until the next accepted start
//   div_by_zero           set with done when the divisor was zero
module sub_div_ctrl #(
    parameter logic [3:0] DBZ_QUOTIENT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] sub_a,
    output logic [3:0] sub_b,
    output logic       sub_c,
    input  logic [3:0] sub_diff,
    input  logic       sub_cout,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t     state, state_nx;
    logic [3:0] rem, quo, dvs, rem_nx, quo_nx;
    logic [1:0] step;
    logic       calc, accept, take;
    assign calc   = state == CALC;
    assign accept = state == IDLE && start;
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    // Shift the next dividend bit into the partial remainder and trial-subtract;
    // the partial remainder stays below 8 so the shifted value fits in 4 bits.
    assign sub_a  = calc ? {rem[2:0], quo[3]} : 4'd0;
    assign sub_b  = calc ? dvs : 4'd0;
    assign sub_c  = 1'b0;
    assign take   = ~sub_cout;
    assign rem_nx = take ? sub_diff : sub_a;
    assign quo_nx = {quo[2:0], take};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = IDLE;
        state_nx = state == IDLE ? (start ? (divisor == 4'd0 ? DONE : CALC) : IDLE) :
                   state == CALC ? (step == 2'd3 ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rem         <= 4'd0;
            quo         <= 4'd0;
            dvs         <= 4'd0;
            step        <= 2'd0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == 4'd0) begin
                quotient    <= DBZ_QUOTIENT;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                rem         <= 4'd0;
                quo         <= dividend;
                dvs         <= divisor;
                step        <= 2'd0;
                div_by_zero <= 1'b0;
            end
        end else if (calc) begin
            rem  <= rem_nx;
            quo  <= quo_nx;
            step <= step + 2'd1;
            if (step == 2'd3) begin
                quotient  <= quo_nx;
                remainder <= rem_nx;
            end
        end
endmodule
